// File: rtl/vga_pkg.sv
// VGA timing defaults (640x480@60), test-pattern source encoding and frame-size helpers.
// Latency: none, declarations only.
// Backpressure: not applicable.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // pixel source selection carried on pat_sel
  typedef enum logic [1:0] {
    PAT_RAM   = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_BLACK = 2'd3
  } pat_e;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline used to align sync/enable/pattern control with pixel RAM data.
// Latency: DEPTH cycles from d to q.
// Backpressure: none, advances every clock.
module vga_delay_line #(
  parameter int             W     = 1,
  parameter int             DEPTH = 1,
  parameter logic [W-1:0]   RST   = '0
) (
  input  logic         vga_clk,
  input  logic         clrn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  // shift register; every stage returns to the idle control word on reset
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scanner: counters, pixel-RAM addressing, test patterns, aligned sync/de/colour.
// Latency: address/rdn 1 cycle after the count; r/g/b/de/hs/vs/frame_start RD_LAT+2 cycles.
// Backpressure: none, free-running at the pixel clock.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                        vga_clk,
  input  logic                        clrn,
  input  logic [3*CW-1:0]             d_in,
  input  logic [1:0]                  pat_sel,
  output logic [$clog2(V_ACTIVE)-1:0] row_addr,
  output logic [$clog2(H_ACTIVE)-1:0] col_addr,
  output logic                        rdn,
  output logic [CW-1:0]               r,
  output logic [CW-1:0]               g,
  output logic [CW-1:0]               b,
  output logic                        de,
  output logic                        hs,
  output logic                        vs,
  output logic                        frame_start
);

  localparam int HT    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HCW   = $clog2(HT);
  localparam int VCW   = $clog2(VT);
  localparam int RW    = $clog2(V_ACTIVE);
  localparam int CLW   = $clog2(H_ACTIVE);
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int CTW   = 5 + 3*CW;

  localparam logic [HCW-1:0] H_LAST     = HCW'(HT - 1);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_ACT_BEG  = HCW'(H_SYNC + H_BP);
  localparam logic [HCW:0]   H_ACT_END  = (HCW+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCW-1:0] V_LAST     = VCW'(VT - 1);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_ACT_BEG  = VCW'(V_SYNC + V_BP);
  localparam logic [VCW:0]   V_ACT_END  = (VCW+1)'(V_SYNC + V_BP + V_ACTIVE);

  // idle control word: {frame_start, hs, vs, de, use_ram, rgb}
  localparam logic [CTW-1:0] CTRL_RST = {1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, {3*CW{1'b0}}};

  logic [HCW-1:0]  h_cnt;
  logic [VCW-1:0]  v_cnt;
  logic [HCW-1:0]  col_full;
  logic [HCW-1:0]  bar_raw;
  logic [2:0]      bar;
  logic            h_act, v_act, vis;
  logic            hs_a, vs_a, fs_a, use_ram;
  logic [3*CW-1:0] pat_rgb;
  logic [CTW-1:0]  ctrl, ctrl_dl;
  pat_e            pat_q;

  // raster counters: h wraps every line, v advances on h wrap
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VCW'(1);
    end else begin
      h_cnt <= h_cnt + HCW'(1);
    end
  end

  assign col_full = h_cnt - H_ACT_BEG;
  assign h_act    = (h_cnt >= H_ACT_BEG) && ({1'b0, h_cnt} < H_ACT_END);
  assign v_act    = (v_cnt >= V_ACT_BEG) && ({1'b0, v_cnt} < V_ACT_END);
  assign vis      = h_act && v_act;
  assign hs_a     = (h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
  assign vs_a     = (v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
  assign fs_a     = (h_cnt == '0) && (v_cnt == '0);
  assign bar_raw  = col_full / HCW'(BAR_W);
  assign bar      = (bar_raw > HCW'(7)) ? 3'd7 : bar_raw[2:0];
  assign use_ram  = (pat_q == PAT_RAM);

  // pattern source only changes at the top-left count so a frame never mixes sources
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) pat_q <= PAT_RAM;
    else if (fs_a) pat_q <= pat_e'(pat_sel);
  end

  // generated colour for the current count, packed {b,g,r} like d_in
  always_comb begin
    pat_rgb = '0;
    case (pat_q)
      PAT_BARS:  pat_rgb = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      PAT_WHITE: pat_rgb = '1;
      default:   pat_rgb = '0;
    endcase
  end

  // RAM address and read strobe, one cycle after the count they describe
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      row_addr <= '0;
      col_addr <= '0;
      rdn      <= 1'b1;
    end else begin
      row_addr <= RW'(v_cnt - V_ACT_BEG);
      col_addr <= CLW'(col_full);
      rdn      <= ~vis;
    end
  end

  assign ctrl = {fs_a, hs_a, vs_a, vis, use_ram, pat_rgb};

  // one stage for the address register plus RD_LAT stages for the RAM read
  vga_delay_line #(
    .W     (CTW),
    .DEPTH (RD_LAT + 1),
    .RST   (CTRL_RST)
  ) u_align (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .d       (ctrl),
    .q       (ctrl_dl)
  );

  // output register: merges RAM data or pattern with the aligned control, blanks outside de
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      {b, g, r}   <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ctrl_dl[CTW-1];
      hs          <= ctrl_dl[CTW-2];
      vs          <= ctrl_dl[CTW-3];
      de          <= ctrl_dl[CTW-4];
      if (!ctrl_dl[CTW-4])     {b, g, r} <= '0;
      else if (ctrl_dl[CTW-5]) {b, g, r} <= d_in;
      else                     {b, g, r} <= ctrl_dl[3*CW-1:0];
    end
  end

endmodule
